apb_master_seq: RTL and testbench
=================================

# apb_master_seq

Single-clock APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers on `pselx`, `penable`, `pwrite`, `paddr` and `pwdata`. It samples `prdata` and returns one response per command. It is the requester end of the APB link: it drives the signals the APB slave side samples, and consumes the `prdata` that side drives. The protocol has no `pready` or `pslverr`, so every ACCESS phase lasts exactly one cycle.

## Interface
- `ADDR_W`, 32, command/APB address width
- `DATA_W`, 32, data width
- `FIFO_DEPTH`, 4, command FIFO entries (power of 2); used only with `APB_MASTER_CMD_FIFO_EN`

Ports:
- `clock`  in  1  sole clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `rsp_err`  out  1  address decoded to no slave
- `pselx`  out  4  one-hot slave select
- `penable`  out  1  ACCESS phase
- `pwrite`  out  1  transfer direction
- `paddr`  out  ADDR_W  transfer address
- `pwdata`  out  DATA_W  write data
- `prdata`  in  DATA_W  read data from the selected slave

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when a command is available, either buffered or being accepted this cycle.
  - SETUP→ACCESS always.
  - ACCESS→SETUP if another command is available, else ACCESS→IDLE.
- Address decode on `cmd_addr[31:26]`:
  - 0x8000_0000–0x83FF_FFFF → `pselx` 4'b0001
  - 0x8400_0000–0x87FF_FFFF → 4'b0010
  - 0x8800_0000–0x8BFF_FFFF → 4'b0100
  - 0x8C00_0000–0x8FFF_FFFF → 4'b1000
  - Anything else is a decode error.
- Decode-error command:
  - Occupies the SETUP and ACCESS slots with `pselx`=0 and `penable`=0, so the bus stays idle.
  - Returns `rsp_err`=1 and `rsp_rdata`=0 at normal latency.
- `pselx`, `pwrite`, `paddr` and `pwdata` are registered and stable across SETUP and ACCESS.
- `penable`=1 only in ACCESS.
- `prdata` is captured at the rising edge that ends ACCESS, for reads only.
- In IDLE: `pselx`=0 and `penable`=0; `paddr`, `pwrite` and `pwdata` hold their last values.
- Without the FIFO, a one-entry holding register sits in front of the FSM; `cmd_ready` = !holding-valid.
- A command accepted while the FSM is in IDLE, or in ACCESS with the buffer empty, bypasses the buffer and loads the APB registers directly.
- A handshake in the same cycle as a buffer pop is legal and keeps order.
- Responses are returned strictly in command order.

## Timing
- Cycle 0: `cmd_valid` && `cmd_ready`.
- Cycle 1: SETUP.
- Cycle 2: ACCESS.
- Cycle 3: `rsp_valid`=1, with `rsp_rdata` set to the `prdata` sampled at the end of cycle 2.
- Back-to-back commands give a sustained rate of one transfer per 2 cycles (SETUP, ACCESS, SETUP, ...) with no IDLE gap between them.
- Reset values (asserted asynchronously):
  - all outputs 0, except `cmd_ready`=1
  - FSM in IDLE
  - buffer/FIFO emptied
- Reset mid-transfer: the bus drops to idle immediately, in-flight and buffered commands are discarded, and no response is issued.
- After `resetn` rises, the first command can be accepted in the first clock cycle.
- `rsp_valid` for transfer N may coincide with the SETUP of transfer N+1 and with a new `cmd` handshake.

## Configuration
- `APB_MASTER_CMD_FIFO_EN` defined:
  - Commands queue in a FIFO of `FIFO_DEPTH` entries.
  - `cmd_ready` = !full.
  - The bypass rule still applies when the FIFO is empty.
- `APB_MASTER_CMD_FIFO_EN` undefined:
  - Uses the single holding register instead.
  - Cycle-level APB behaviour is identical; only acceptance depth differs.

## Structure
- Package `apb_master_pkg` holds:
  - the state enum `apb_state_t` (IDLE, SETUP, ACCESS)
  - the four slave base constants and the region size
  - a command struct `apb_cmd_t` (write, addr, wdata)
  - a function `apb_decode()` returning `pselx` and an error flag
- Sub-module `apb_cmd_fifo` (parameterised depth, push/pop, full/empty) is instantiated only under `APB_MASTER_CMD_FIFO_EN`.

## Test plan
- **Single write:** write to 0x8000_0010 with data 0xDEAD_BEEF.
  - SETUP in cycle 1: `pselx`=0001, `pwrite`=1, `paddr`=0x8000_0010, `pwdata`=0xDEAD_BEEF, `penable`=0.
  - `penable`=1 in cycle 2.
  - `rsp_valid` in cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
- **Single read:** read of 0x8C00_0004 with `prdata`=0x1234_5678 during ACCESS.
  - `pselx`=1000.
  - `rsp_rdata`=0x1234_5678 in cycle 3.
- **Decode error:** read of 0x9000_0000.
  - `pselx` and `penable` stay 0 throughout.
  - `rsp_valid` in cycle 3 with `rsp_err`=1 and `rsp_rdata`=0.
- **Back-to-back traffic:** 4 commands, one per slave, with `cmd_valid` held high.
  - No IDLE between transfers; `penable` toggles 0,1,0,1,...
  - 4 in-order responses spaced 2 cycles apart.
  - With the FIFO, `cmd_ready` stays high until the FIFO is full.
- **Reset mid-ACCESS:** assert `resetn` low during ACCESS.
  - `pselx`, `penable` and `rsp_valid` go to 0 without waiting for a clock edge.
  - No response appears after reset is released.
  - The next command completes with normal 3-cycle latency.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types, slave address map and address decode for apb_master_seq.
package apb_master_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [31:0] SLV0_BASE   = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE   = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE   = 32'h8800_0000;
  localparam logic [31:0] SLV3_BASE   = 32'h8C00_0000;
  localparam logic [31:0] REGION_SIZE = 32'h0400_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [3:0] sel;
    logic       err;
  } apb_dec_t;

  // Regions are size-aligned, so masking off the in-region offset leaves the base.
  function automatic apb_dec_t apb_decode(input logic [CMD_ADDR_W-1:0] addr);
    apb_dec_t   d;
    logic [31:0] base;
    base  = addr[31:0] & ~(REGION_SIZE - 32'd1);
    d.sel = 4'b0000;
    if (base == SLV0_BASE)      d.sel = 4'b0001;
    else if (base == SLV1_BASE) d.sel = 4'b0010;
    else if (base == SLV2_BASE) d.sel = 4'b0100;
    else if (base == SLV3_BASE) d.sel = 4'b1000;
    d.err = (d.sel == 4'b0000);
    return d;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for apb_master_seq; only instantiated when APB_MASTER_CMD_FIFO_EN is defined.
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     resetn,
  input  logic     push,
  input  logic     pop,
  input  apb_cmd_t din,
  output apb_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_master_seq.sv
// APB initiator: valid/ready commands in, SETUP/ACCESS transfers out, one response per command.
// APB_MASTER_CMD_FIFO_EN selects a FIFO_DEPTH command queue instead of a single holding register.
//
// state  | meaning
// IDLE   | no transfer in flight, bus idle
// SETUP  | APB registers loaded, pselx up, penable low
// ACCESS | penable high for one cycle, prdata captured at its end
module apb_master_seq
  import apb_master_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [3:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_t state, state_nxt;
  apb_cmd_t   cmd_in, buf_cmd, next_cmd;
  apb_dec_t   next_dec;
  logic       buf_empty, accept, load, push, pop, err_q;

  assign cmd_in = {cmd_write, cmd_addr, cmd_wdata};
  assign accept = cmd_valid && cmd_ready;

`ifdef APB_MASTER_CMD_FIFO_EN
  logic fifo_full;

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (cmd_in),
    .dout   (buf_cmd),
    .full   (fifo_full),
    .empty  (buf_empty)
  );

  assign cmd_ready = !fifo_full;
`else
  logic        hold_valid;
  apb_cmd_t    hold_cmd;
  logic [31:0] unused_fifo_depth;

  // FIFO_DEPTH only sizes the queued build.
  assign unused_fifo_depth = FIFO_DEPTH;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_cmd   <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_cmd   <= cmd_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_cmd   = hold_cmd;
  assign buf_empty = !hold_valid;
  assign cmd_ready = !hold_valid;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A command arriving when nothing is buffered skips the buffer and loads the bus directly.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (accept || !buf_empty) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (accept || !buf_empty) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pop  = load && !buf_empty;
    push = accept && !(load && buf_empty);
  end

  assign next_cmd = buf_empty ? cmd_in : buf_cmd;
  assign next_dec = apb_decode(next_cmd.addr);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pselx     <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == ACCESS);
      rsp_err   <= (state == ACCESS) && err_q;
      rsp_rdata <= (state == ACCESS && !pwrite && !err_q) ? prdata : '0;
      penable   <= (state == SETUP) && !err_q;
      if (load) begin
        pselx  <= next_dec.sel;
        err_q  <= next_dec.err;
        pwrite <= next_cmd.write;
        paddr  <= next_cmd.addr;
        pwdata <= next_cmd.wdata;
      end else if (state == ACCESS) begin
        pselx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_seq.sv
// Self-checking bench for apb_master_seq against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_apb_master_seq;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, prdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [3:0]  pselx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_setup = -10;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
    int          setup;
  } txn_t;

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic        re;
    logic [31:0] rd;
    logic        rdy;
  } exp_t;

  txn_t        q[$];
  logic [31:0] prd_hist [int];

  always #5 clock = ~clock;

  apb_master_seq dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  // Slave map: four 64 MiB windows starting at 0x8000_0000.
  function automatic logic [3:0] slave_sel(input logic [31:0] a);
    if (a < 32'h8000_0000 || a >= 32'h9000_0000) return 4'b0000;
    return 4'b0001 << ((a - 32'h8000_0000) / 32'h0400_0000);
  endfunction

  // Expected pins in cycle t: each command owns [setup, setup+1] on the bus and answers at setup+2.
  function automatic exp_t model_at(int t);
    exp_t e;
    int   cur;
    int   pend;
    e    = '{default: 0};
    cur  = -1;
    pend = 0;
    foreach (q[i]) begin
      if (q[i].setup <= t) cur = i;
      if (q[i].acc < t && q[i].setup > t) pend++;
      if (q[i].setup + 2 == t) begin
        e.rv = 1'b1;
        e.re = (slave_sel(q[i].addr) == 4'b0000);
        e.rd = (q[i].wr || e.re) ? 32'h0 : prd_hist[q[i].setup + 1];
      end
    end
    if (cur >= 0 && t - q[cur].setup <= 1) begin
      e.sel   = slave_sel(q[cur].addr);
      e.en    = (t - q[cur].setup == 1) && (e.sel != 4'b0000);
      e.wr    = q[cur].wr;
      e.addr  = q[cur].addr;
      e.wdata = q[cur].wdata;
    end
`ifdef APB_MASTER_CMD_FIFO_EN
    e.rdy = (pend < 4);
`else
    e.rdy = (pend == 0);
`endif
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    prd_hist.delete();
    cyc = 0;
    last_setup = -10;
  endtask

  // Ends one cycle: records any handshake and prdata, then lands 1 ns after the next edge.
  task automatic step(output logic hs);
    hs = cmd_valid && cmd_ready;
    if (hs) begin
      txn_t x;
      x.wr    = cmd_write;
      x.addr  = cmd_addr;
      x.wdata = cmd_wdata;
      x.acc   = cyc;
      x.setup = (cyc + 1 > last_setup + 2) ? cyc + 1 : last_setup + 2;
      last_setup = x.setup;
      q.push_back(x);
    end
    prd_hist[cyc] = prdata;
    @(posedge clock);
    #1;
    cyc++;
    prdata = $urandom;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({pselx, penable, pwrite, rsp_valid, rsp_err, cmd_ready} !== 9'b0_0000_0001) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {pselx, penable, pwrite, rsp_valid, rsp_err, cmd_ready}, 9'b1);
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0 || pselx !== 4'b0000 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_held got paddr=%h pwdata=%h rdata=%h pselx=%b ready=%b exp zeros/ready=1",
               paddr, pwdata, rsp_rdata, pselx, cmd_ready);
    end
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_single_write();
    logic hs;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0010; cmd_wdata = 32'hDEAD_BEEF;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", cmd_ready); end
    step(hs);
    cmd_valid = 1'b0;
    total++;
    if ({pselx, penable, pwrite} !== 6'b0001_0_1 || paddr !== 32'h8000_0010 || pwdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL wr_setup got sel=%b en=%b wr=%b addr=%h data=%h exp 0001/0/1/80000010/deadbeef",
               pselx, penable, pwrite, paddr, pwdata);
    end
    step(hs);
    total++;
    if ({pselx, penable, pwrite} !== 6'b0001_1_1 || paddr !== 32'h8000_0010) begin
      bad++;
      $display("FAIL wr_access got sel=%b en=%b wr=%b addr=%h exp 0001/1/1/80000010", pselx, penable, pwrite, paddr);
    end
    step(hs);
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0 || {pselx, penable} !== 5'b0) begin
      bad++;
      $display("FAIL wr_rsp got v=%b e=%b d=%h sel=%b en=%b exp 1/0/0/0000/0", rsp_valid, rsp_err, rsp_rdata, pselx, penable);
    end
    step(hs);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_once got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_single_read();
    logic hs;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8C00_0004; cmd_wdata = $urandom;
    step(hs);
    cmd_valid = 1'b0;
    total++;
    if ({pselx, penable, pwrite} !== 6'b1000_0_0 || paddr !== 32'h8C00_0004) begin
      bad++;
      $display("FAIL rd_setup got sel=%b en=%b wr=%b addr=%h exp 1000/0/0/8c000004", pselx, penable, pwrite, paddr);
    end
    step(hs);
    prdata = 32'h1234_5678;
    total++;
    if ({pselx, penable} !== 5'b1000_1) begin
      bad++;
      $display("FAIL rd_access got sel=%b en=%b exp 1000/1", pselx, penable);
    end
    step(hs);
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rd_rsp got v=%b e=%b d=%h exp 1/0/12345678", rsp_valid, rsp_err, rsp_rdata);
    end
    step(hs);
  endtask

  task automatic test_decode_err();
    logic hs;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h9000_0000; cmd_wdata = '0;
    step(hs);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      prdata = 32'hA5A5_0000 | i;
      total++;
      if ({pselx, penable} !== 5'b0) begin
        bad++;
        $display("FAIL err_bus_c%0d got sel=%b en=%b exp 0000/0", i, pselx, penable);
      end
      step(hs);
    end
    total++;
    if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL err_rsp got v=%b e=%b d=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    step(hs);
  endtask

  task automatic test_back_to_back();
    logic        hs;
    logic [31:0] ad [4];
    logic [31:0] wd [4];
    logic        wr [4];
    exp_t        e;
    int k = 0, n_rsp = 0, last_rsp = -1, busy = 0, first_busy = -1, last_busy = -1;
    for (int i = 0; i < 4; i++) begin
      ad[i] = 32'h8000_0000 + i * 32'h0400_0000 + $urandom_range(0, 32'h03FF_FFFF);
      wd[i] = $urandom;
      wr[i] = $urandom_range(0, 1);
    end
    for (int c = 0; c < 30; c++) begin
      cmd_valid = (k < 4);
      if (k < 4) begin cmd_write = wr[k]; cmd_addr = ad[k]; cmd_wdata = wd[k]; end
      step(hs);
      if (hs) k++;
      e = model_at(cyc);
      total++;
      if ({pselx, penable, cmd_ready} !== {e.sel, e.en, e.rdy}) begin
        bad++;
        $display("FAIL b2b_bus cyc=%0d got sel=%b en=%b rdy=%b exp %b/%b/%b", cyc, pselx, penable, cmd_ready, e.sel, e.en, e.rdy);
      end
      total++;
      if (rsp_valid !== e.rv || (e.rv && (rsp_rdata !== e.rd || rsp_err !== e.re))) begin
        bad++;
        $display("FAIL b2b_rsp cyc=%0d got v=%b d=%h e=%b exp %b/%h/%b", cyc, rsp_valid, rsp_rdata, rsp_err, e.rv, e.rd, e.re);
      end
      if (pselx != 4'b0000) begin
        busy++;
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
      end
      if (rsp_valid) begin
        if (last_rsp >= 0) begin
          total++;
          if (cyc - last_rsp != 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=2", cyc - last_rsp); end
        end
        last_rsp = cyc;
        n_rsp++;
      end
      if (k == 4 && n_rsp == 4) break;
    end
    cmd_valid = 1'b0;
    total++;
    if (n_rsp != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n_rsp); end
    total++;
    if (busy != 8 || last_busy - first_busy != 7) begin
      bad++;
      $display("FAIL b2b_no_gap got busy=%0d span=%0d exp 8/8", busy, last_busy - first_busy + 1);
    end
  endtask

  task automatic test_random();
    logic hs;
    exp_t e;
    int   sent = 0;
    bit   done = 0;
    for (int c = 0; c < 400; c++) begin
      if (!cmd_valid && sent < 30 && $urandom_range(0, 9) < 7) begin
        int r = $urandom_range(0, 4);
        cmd_valid = 1'b1;
        cmd_write = $urandom_range(0, 1);
        cmd_wdata = $urandom;
        if (r < 4) begin
          cmd_addr = 32'h8000_0000 + r * 32'h0400_0000 + $urandom_range(0, 32'h03FF_FFFF);
        end else begin
          cmd_addr = $urandom;
          if (cmd_addr[31:28] == 4'h8) cmd_addr[31:28] = 4'h9;
        end
      end
      step(hs);
      if (hs) begin sent++; cmd_valid = 1'b0; end
      e = model_at(cyc);
      total++;
      if ({pselx, penable, cmd_ready} !== {e.sel, e.en, e.rdy} ||
          (e.sel != 4'b0000 && {pwrite, paddr, pwdata} !== {e.wr, e.addr, e.wdata})) begin
        bad++;
        $display("FAIL rnd_bus cyc=%0d got sel=%b en=%b rdy=%b wr=%b a=%h d=%h exp %b/%b/%b/%b/%h/%h", cyc,
                 pselx, penable, cmd_ready, pwrite, paddr, pwdata, e.sel, e.en, e.rdy, e.wr, e.addr, e.wdata);
      end
      total++;
      if (rsp_valid !== e.rv || (e.rv && (rsp_rdata !== e.rd || rsp_err !== e.re))) begin
        bad++;
        $display("FAIL rnd_rsp cyc=%0d got v=%b d=%h e=%b exp %b/%h/%b", cyc, rsp_valid, rsp_rdata, rsp_err, e.rv, e.rd, e.re);
      end
      if (sent == 30 && cyc > last_setup + 3) begin done = 1; break; end
    end
    cmd_valid = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL rnd_timeout got sent=%0d exp 30 drained", sent); end
  endtask

  task automatic test_reset_mid();
    logic hs;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8400_0008;
    step(hs);
    cmd_write = 1'b1; cmd_addr = 32'h8800_0000; cmd_wdata = $urandom;
    step(hs);
    cmd_valid = 1'b0;
    total++;
    if ({pselx, penable} !== 5'b0010_1) begin
      bad++;
      $display("FAIL rm_pre got sel=%b en=%b exp 0010/1", pselx, penable);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({pselx, penable, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL rm_async got sel=%b en=%b v=%b exp 0000/0/0", pselx, penable, rsp_valid);
    end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(hs);
      total++;
      if ({pselx, penable, rsp_valid} !== 6'b0) begin
        bad++;
        $display("FAIL rm_quiet c%0d got sel=%b en=%b v=%b exp 0000/0/0", i, pselx, penable, rsp_valid);
      end
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8C00_0010;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", cmd_ready); end
    step(hs);
    cmd_valid = 1'b0;
    total++;
    if ({pselx, penable} !== 5'b1000_0 || paddr !== 32'h8C00_0010) begin
      bad++;
      $display("FAIL rm_setup got sel=%b en=%b a=%h exp 1000/0/8c000010", pselx, penable, paddr);
    end
    step(hs);
    prdata = 32'h0BAD_F00D;
    total++;
    if ({pselx, penable} !== 5'b1000_1) begin bad++; $display("FAIL rm_access got sel=%b en=%b exp 1000/1", pselx, penable); end
    step(hs);
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL rm_rsp got v=%b e=%b d=%h exp 1/0/0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
    step(hs);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_decode_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
